seq_ctrl_ws: RTL and testbench



---
 rtl/seq_ctrl_ws.sv | 181 ++++++++++++++++++
 tb/tb_seq_ctrl_ws.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_ws
// Purpose  : VeriRISC sequence controller. Steps the 8-phase fetch/execute
//            cycle (INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR,
//            OP_FETCH, ALU_OP, STORE) and adds a HALTED state. The two
//            memory-read fetch phases can be stretched by MEM_WAIT cycles.
// Ports    : clk     - clock, rising edge
//            rst_    - asynchronous active-low reset
//            opcode  - IR opcode (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5
//                      STO=6 JMP=7)
//            zero    - accumulator-zero flag
//            resume  - one-cycle pulse that leaves HALTED
//            load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt
//                    - combinational datapath enables
//            state_o, retired - status outputs, present only when the
//                      macro SEQ_CTRL_WS_STATUS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl_ws #(
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4
`ifdef SEQ_CTRL_WS_STATUS_EN
  ,
  parameter int RETIRE_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [2:0]          opcode,
  input  logic                zero,
  input  logic                resume,
  output logic                load_ac,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                inc_pc,
  output logic                load_pc,
  output logic                load_ir,
  output logic                halt
`ifdef SEQ_CTRL_WS_STATUS_EN
  ,
  output logic [3:0]          state_o,
  output logic [RETIRE_W-1:0] retired
`endif
);

  // State encodings
  localparam logic [3:0] c_INST_ADDR  = 4'd0;
  localparam logic [3:0] c_INST_FETCH = 4'd1;
  localparam logic [3:0] c_INST_LOAD  = 4'd2;
  localparam logic [3:0] c_IDLE       = 4'd3;
  localparam logic [3:0] c_OP_ADDR    = 4'd4;
  localparam logic [3:0] c_OP_FETCH   = 4'd5;
  localparam logic [3:0] c_ALU_OP     = 4'd6;
  localparam logic [3:0] c_STORE      = 4'd7;
  localparam logic [3:0] c_HALTED     = 4'd8;

  // Opcodes
  localparam logic [2:0] c_HLT = 3'd0;
  localparam logic [2:0] c_SKZ = 3'd1;
  localparam logic [2:0] c_ADD = 3'd2;
  localparam logic [2:0] c_AND = 3'd3;
  localparam logic [2:0] c_XOR = 3'd4;
  localparam logic [2:0] c_LDA = 3'd5;
  localparam logic [2:0] c_STO = 3'd6;
  localparam logic [2:0] c_JMP = 3'd7;

  localparam logic [WAIT_W-1:0] c_WAIT_TGT = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] c_WAIT_ONE = WAIT_W'(1);

  logic [3:0]        r_state;
  logic [3:0]        w_next_state;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_next_wait;
  logic              w_aluop;
  logic              w_wait_done;

  // Opcodes that read an operand from memory and load the accumulator
  assign w_aluop = (opcode == c_ADD) || (opcode == c_AND) ||
                   (opcode == c_XOR) || (opcode == c_LDA);

  assign w_wait_done = (r_wait == c_WAIT_TGT);

  // Next-state logic. The wait counter defaults to 0 so it is always
  // cleared on entry to a wait-capable phase and only counts while held.
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = '0;
    case (r_state)
      c_INST_ADDR:  w_next_state = c_INST_FETCH;
      c_INST_FETCH: begin
        if (w_wait_done) w_next_state = c_INST_LOAD;
        else             w_next_wait  = r_wait + c_WAIT_ONE;
      end
      c_INST_LOAD:  w_next_state = c_IDLE;
      c_IDLE:       w_next_state = c_OP_ADDR;
      c_OP_ADDR:    w_next_state = (opcode == c_HLT) ? c_HALTED : c_OP_FETCH;
      c_OP_FETCH: begin
        // Only operand reads are stretched; other opcodes pass in one cycle
        if (!w_aluop || w_wait_done) w_next_state = c_ALU_OP;
        else                         w_next_wait  = r_wait + c_WAIT_ONE;
      end
      c_ALU_OP:     w_next_state = c_STORE;
      c_STORE:      w_next_state = c_INST_ADDR;
      c_HALTED: begin
        if (resume) w_next_state = c_INST_ADDR;
      end
      default:      w_next_state = c_INST_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= c_INST_ADDR;
      r_wait  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_next_wait;
    end
  end

  // Output decode from current state, opcode and zero flag
  always_comb begin
    load_ac = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    case (r_state)
      c_INST_FETCH: mem_rd = 1'b1;
      c_INST_LOAD, c_IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      c_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == c_HLT);
      end
      c_OP_FETCH:   mem_rd = w_aluop;
      c_ALU_OP: begin
        load_ac = w_aluop;
        mem_rd  = w_aluop;
        inc_pc  = (opcode == c_SKZ) && zero;
        load_pc = (opcode == c_JMP);
      end
      c_STORE: begin
        load_ac = w_aluop;
        mem_rd  = w_aluop;
        mem_wr  = (opcode == c_STO);
        inc_pc  = (opcode == c_JMP);
        load_pc = (opcode == c_JMP);
      end
      c_HALTED:     halt = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_CTRL_WS_STATUS_EN
  logic [RETIRE_W-1:0] r_retired;
  logic                w_retire;

  // An instruction retires when STORE completes, or when HLT enters HALTED
  assign w_retire = (r_state == c_STORE) ||
                    ((r_state == c_OP_ADDR) && (opcode == c_HLT));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign state_o = r_state;
  assign retired = r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_ctrl_ws
// Purpose  : Scoreboard bench for seq_ctrl_ws. Three instances with
//            MEM_WAIT = 0, 2 and 5 share clock and inputs; each scenario
//            pushes the expected per-cycle output vectors of an instruction
//            and then pops and compares them against the selected instance.
//            Status outputs are checked when SEQ_CTRL_WS_STATUS_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl_ws;

  localparam logic [3:0] S_IA = 4'd0, S_IF = 4'd1, S_IL = 4'd2, S_ID = 4'd3,
                         S_OA = 4'd4, S_OF = 4'd5, S_AL = 4'd6, S_ST = 4'd7,
                         S_HT = 4'd8;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                         XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct packed {
    logic [6:0] outs;  // {load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt}
    logic [3:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [2:0] opcode = ADD;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  logic [6:0] out0, out2, out5;
  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail = 0;

`ifdef SEQ_CTRL_WS_STATUS_EN
  logic [3:0]  st0, st2, st5;
  logic [3:0]  ret0;
  logic [15:0] ret2, ret5;
`endif

  always #5 clk = ~clk;

  seq_ctrl_ws #(
    .MEM_WAIT(0)
`ifdef SEQ_CTRL_WS_STATUS_EN
    , .RETIRE_W(4)
`endif
  ) u_dut0 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .resume(resume),
    .load_ac(out0[6]), .mem_rd(out0[5]), .mem_wr(out0[4]), .inc_pc(out0[3]),
    .load_pc(out0[2]), .load_ir(out0[1]), .halt(out0[0])
`ifdef SEQ_CTRL_WS_STATUS_EN
    , .state_o(st0), .retired(ret0)
`endif
  );

  seq_ctrl_ws #(.MEM_WAIT(2)) u_dut2 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .resume(resume),
    .load_ac(out2[6]), .mem_rd(out2[5]), .mem_wr(out2[4]), .inc_pc(out2[3]),
    .load_pc(out2[2]), .load_ir(out2[1]), .halt(out2[0])
`ifdef SEQ_CTRL_WS_STATUS_EN
    , .state_o(st2), .retired(ret2)
`endif
  );

  seq_ctrl_ws #(.MEM_WAIT(5)) u_dut5 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .resume(resume),
    .load_ac(out5[6]), .mem_rd(out5[5]), .mem_wr(out5[4]), .inc_pc(out5[3]),
    .load_pc(out5[2]), .load_ir(out5[1]), .halt(out5[0])
`ifdef SEQ_CTRL_WS_STATUS_EN
    , .state_o(st5), .retired(ret5)
`endif
  );

  function automatic logic [6:0] get_out(input int idx);
    case (idx)
      0:       return out0;
      2:       return out2;
      default: return out5;
    endcase
  endfunction

`ifdef SEQ_CTRL_WS_STATUS_EN
  function automatic logic [3:0] get_state(input int idx);
    case (idx)
      0:       return st0;
      2:       return st2;
      default: return st5;
    endcase
  endfunction
`endif

  // Expected outputs of one phase, taken from the per-state output table
  function automatic logic [6:0] model(input logic [3:0] st, input logic [2:0] op,
                                       input logic z);
    logic alu;
    logic la, rd, wr, ip, lp, li, h;
    alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    {la, rd, wr, ip, lp, li, h} = 7'b0;
    case (st)
      S_IF: rd = 1'b1;
      S_IL, S_ID: begin rd = 1'b1; li = 1'b1; end
      S_OA: begin ip = 1'b1; h = (op == HLT); end
      S_OF: rd = alu;
      S_AL: begin la = alu; rd = alu; ip = (op == SKZ) && z; lp = (op == JMP); end
      S_ST: begin la = alu; rd = alu; wr = (op == STO); ip = (op == JMP); lp = (op == JMP); end
      S_HT: h = 1'b1;
      default: ;
    endcase
    return {la, rd, wr, ip, lp, li, h};
  endfunction

  task automatic push(input logic [3:0] st, input logic [2:0] op, input logic z);
    exp_t e;
    e.outs = model(st, op, z);
    e.st   = st;
    q.push_back(e);
  endtask

  // Expected phase sequence of one instruction starting at INST_ADDR
  task automatic push_instr(input int mw, input logic [2:0] op, input logic z,
                            input int n_halt);
    bit alu;
    alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    push(S_IA, op, z);
    for (int i = 0; i <= mw; i++) push(S_IF, op, z);
    push(S_IL, op, z);
    push(S_ID, op, z);
    push(S_OA, op, z);
    if (op == HLT) begin
      for (int i = 0; i < n_halt; i++) push(S_HT, op, z);
    end else begin
      for (int i = 0; i < (alu ? mw + 1 : 1); i++) push(S_OF, op, z);
      push(S_AL, op, z);
      push(S_ST, op, z);
    end
  endtask

  // Pop and compare one expectation per cycle; pulse resume while the
  // expected phase equals resume_st (-1 = never)
  task automatic drain(input int idx, input int resume_st, input string tag);
    exp_t e;
    int   cyc;
    cyc = 1;
    while (q.size() > 0) begin
      e = q.pop_front();
      resume = (resume_st == int'(e.st));
      n_tests++;
      if (get_out(idx) !== e.outs) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d phase %0d: outputs got %b expected %b",
                 tag, idx, cyc, e.st, get_out(idx), e.outs);
      end
`ifdef SEQ_CTRL_WS_STATUS_EN
      n_tests++;
      if (get_state(idx) !== e.st) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d state_o got %0d expected %0d",
                 tag, idx, cyc, get_state(idx), e.st);
      end
`endif
      @(posedge clk); #1;
      resume = 1'b0;
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_tests++;
    if ({out0, out2, out5} !== 21'b0) begin
      n_fail++;
      $display("FAIL %s: outputs got %b/%b/%b expected all 0", tag, out0, out2, out5);
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_held");
`ifdef SEQ_CTRL_WS_STATUS_EN
    n_tests++;
    if (ret0 !== 4'd0 || st0 !== S_IA) begin
      n_fail++;
      $display("FAIL reset_status: retired %0d state %0d expected 0 0", ret0, st0);
    end
`endif
    @(posedge clk); #1;
    rst_ = 1'b1;
    check_all_zero("reset_first_cycle");
  endtask

  task automatic test_add_basic();
    test_reset();
    opcode = ADD; zero = 1'b0;
    push_instr(0, ADD, 1'b0, 0);
    push_instr(0, ADD, 1'b0, 0);
    drain(0, -1, "add_mw0");
  endtask

  task automatic test_wait_states();
    test_reset();
    opcode = LDA;
    push_instr(2, LDA, 1'b0, 0);
    drain(2, -1, "lda_mw2");
    opcode = STO;
    push_instr(2, STO, 1'b0, 0);
    push(S_IA, STO, 1'b0);
    drain(2, -1, "sto_mw2");
  endtask

  task automatic test_skz_jmp();
    test_reset();
    opcode = SKZ; zero = 1'b1;
    push_instr(0, SKZ, 1'b1, 0);
    drain(0, -1, "skz_zero1");
    zero = 1'b0;
    push_instr(0, SKZ, 1'b0, 0);
    drain(0, -1, "skz_zero0");
    opcode = JMP;
    push_instr(0, JMP, 1'b0, 0);
    push(S_IA, JMP, 1'b0);
    drain(0, -1, "jmp");
  endtask

  task automatic test_halt_resume();
    test_reset();
    opcode = ADD;
    push_instr(0, ADD, 1'b0, 0);
    drain(0, int'(S_IL), "resume_in_inst_load");
    opcode = HLT;
    push_instr(0, HLT, 1'b0, 20);
    drain(0, -1, "halt_hold");
    push(S_HT, HLT, 1'b0);
    drain(0, int'(S_HT), "halt_resume");
    opcode = ADD;
    push_instr(0, ADD, 1'b0, 0);
    drain(0, -1, "after_resume");
  endtask

  task automatic test_resume_at_op_addr();
    test_reset();
    opcode = HLT;
    push_instr(2, HLT, 1'b0, 4);
    drain(2, int'(S_OA), "resume_in_op_addr");
    push(S_HT, HLT, 1'b0);
    drain(2, int'(S_HT), "resume_mw2");
    opcode = XOR_;
    push_instr(2, XOR_, 1'b0, 0);
    drain(2, -1, "xor_after_resume");
  endtask

  task automatic test_async_reset();
    test_reset();
    opcode = ADD;
    repeat (4) begin @(posedge clk); #1; end
    n_tests++;
    if (out5 !== 7'b0100000) begin
      n_fail++;
      $display("FAIL mid_wait_fetch: outputs got %b expected %b", out5, 7'b0100000);
    end
    #2 rst_ = 1'b0;
    #1 check_all_zero("async_reset_mid_wait");
    @(posedge clk); #1;
    rst_ = 1'b1;
    push_instr(5, ADD, 1'b0, 0);
    push(S_IA, ADD, 1'b0);
    drain(5, -1, "wait_after_reset");
  endtask

  task automatic test_back_to_back();
    test_reset();
    opcode = AND_;
    push_instr(0, AND_, 1'b0, 0);
    drain(0, -1, "b2b_and");
    opcode = XOR_;
    push_instr(0, XOR_, 1'b0, 0);
    drain(0, -1, "b2b_xor");
    opcode = STO;
    push_instr(0, STO, 1'b0, 0);
    drain(0, -1, "b2b_sto");
  endtask

`ifdef SEQ_CTRL_WS_STATUS_EN
  task automatic test_retire();
    test_reset();
    opcode = ADD;
    for (int i = 0; i < 17; i++) push_instr(0, ADD, 1'b0, 0);
    drain(0, -1, "retire_run");
    n_tests++;
    if (ret0 !== 4'd1) begin
      n_fail++;
      $display("FAIL retired_wrap: got %0d expected 1", ret0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_basic();
    test_wait_states();
    test_skz_jmp();
    test_halt_resume();
    test_resume_at_op_addr();
    test_async_reset();
    test_back_to_back();
`ifdef SEQ_CTRL_WS_STATUS_EN
    test_retire();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
